// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back path.
// Contents:
//   DATA_W, ADDR_W, NUM_REGS : data width, register address width, register count
//   wb_req_t                 : one pending register-file write {rd, data}
//   wb_src_e                 : which unit owns the write port in a given cycle
package regfile_wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of wb_req_t holding LSU load results until the write port is free.
// Ports:
//   clk, RST   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_data at the tail; ignored while full
//   push_data  : entry to store
//   pop        : drop the head entry; ignored while empty
//   head       : current head entry (valid while !empty)
//   full/empty : registered-count status flags
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             push,
  input  wb_req_t          push_data,
  input  logic             pop,
  output wb_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_req_t          mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  // Qualifying with the flags keeps count inside 0..DEPTH whatever the caller does.
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty_s;

  // Entry storage, written at the tail pointer.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{rd: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side controller for the 2R/1W register file.
// Merges single-cycle ALU results and buffered LSU load results onto the one
// write port, and keeps a scoreboard of registers awaiting a load so decode
// can stall on read-after-load hazards.
// Ports:
//   clk, RST                 : clock, asynchronous active-high reset
//   i_alu_valid/rd/data      : ALU result (cannot be back-pressured; wins the port)
//   i_lsu_valid/rd/data      : LSU load result, handshaked with o_lsu_ready
//   o_lsu_ready              : FIFO has room (from registered occupancy only)
//   i_issue_valid/rd         : load issue, marks rd pending
//   i_rs1_addr, i_rs2_addr   : decode-stage source registers
//   o_hazard                 : a source register is pending (combinational)
//   o_pending                : scoreboard vector, bit 0 always 0
//   o_rd_addr/data/wren      : registered register-file write port
// Optional build macro WB_FORWARD_EN adds i_rs1_data/i_rs2_data and
// o_rs1_data/o_rs2_data: the value on the write port is bypassed to decode,
// and a pending bit whose LSU write is on the port no longer stalls.
module regfile_wb_arbiter #(
  parameter int DATA_W     = regfile_wb_pkg::DATA_W,
  parameter int ADDR_W     = regfile_wb_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              i_alu_valid,
  input  logic [ADDR_W-1:0] i_alu_rd,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_lsu_valid,
  output logic              o_lsu_ready,
  input  logic [ADDR_W-1:0] i_lsu_rd,
  input  logic [DATA_W-1:0] i_lsu_data,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_issue_rd,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic              o_hazard,
  output logic [31:0]       o_pending,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_wren
`ifdef WB_FORWARD_EN
  ,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data
`endif
);

  import regfile_wb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [NUM_REGS-1:0] BIT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  wb_req_t             lsu_req_s;
  wb_req_t             fifo_head_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic                fifo_push_s;
  logic                fifo_pop_s;
  logic                alu_take_s;
  logic                lsu_on_port_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] pending_r;
  logic                rs1_haz_s;
  logic                rs2_haz_s;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic                rd_wren_r;
  wb_src_e             rd_src_r;

  assign lsu_req_s.rd   = i_lsu_rd;
  assign lsu_req_s.data = i_lsu_data;

  // Ready comes from the registered count, so a same-cycle pop never makes a full FIFO ready.
  assign o_lsu_ready = (fifo_count_s < CNT_W'(FIFO_DEPTH));
  assign fifo_push_s = i_lsu_valid && !fifo_full_s;

  // An x0 ALU result is dropped and leaves the port free for the FIFO head.
  assign alu_take_s = i_alu_valid && (i_alu_rd != {ADDR_W{1'b0}});
  assign fifo_pop_s = !alu_take_s && !fifo_empty_s;

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .RST      (RST),
    .push     (fifo_push_s),
    .push_data(lsu_req_s),
    .pop      (fifo_pop_s),
    .head     (fifo_head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

  // Write-port register: ALU first, FIFO head second; address/data hold when idle.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rd_addr_r <= {ADDR_W{1'b0}};
      rd_data_r <= {DATA_W{1'b0}};
      rd_wren_r <= 1'b0;
      rd_src_r  <= WB_SRC_ALU;
    end else if (alu_take_s) begin
      rd_addr_r <= i_alu_rd;
      rd_data_r <= i_alu_data;
      rd_wren_r <= 1'b1;
      rd_src_r  <= WB_SRC_ALU;
    end else if (fifo_pop_s) begin
      rd_src_r <= WB_SRC_LSU;
      // An x0 load is consumed without writing anything.
      if (fifo_head_s.rd != {ADDR_W{1'b0}}) begin
        rd_addr_r <= fifo_head_s.rd;
        rd_data_r <= fifo_head_s.data;
        rd_wren_r <= 1'b1;
      end else begin
        rd_wren_r <= 1'b0;
      end
    end else begin
      rd_wren_r <= 1'b0;
    end
  end

  // A pending bit clears only once its LSU write has reached the register file.
  assign lsu_on_port_s = rd_wren_r && (rd_src_r == WB_SRC_LSU);
  assign clr_mask_s = lsu_on_port_s ? (BIT0 << rd_addr_r) : {NUM_REGS{1'b0}};
  assign set_mask_s = (i_issue_valid && (i_issue_rd != {ADDR_W{1'b0}}))
                    ? (BIT0 << i_issue_rd) : {NUM_REGS{1'b0}};

  // Scoreboard: set is applied after clear so a same-cycle set wins; x0 never pends.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      pending_r <= ((pending_r & ~clr_mask_s) | set_mask_s) & ~BIT0;
    end
  end

  assign o_pending = pending_r;

`ifdef WB_FORWARD_EN
  // A load already on the port is bypassed, so its pending bit need not stall decode.
  assign rs1_haz_s = (i_rs1_addr != {ADDR_W{1'b0}}) && pending_r[i_rs1_addr]
                   && !(lsu_on_port_s && (rd_addr_r == i_rs1_addr));
  assign rs2_haz_s = (i_rs2_addr != {ADDR_W{1'b0}}) && pending_r[i_rs2_addr]
                   && !(lsu_on_port_s && (rd_addr_r == i_rs2_addr));
  assign o_rs1_data = (rd_wren_r && (rd_addr_r == i_rs1_addr) && (i_rs1_addr != {ADDR_W{1'b0}}))
                    ? rd_data_r : i_rs1_data;
  assign o_rs2_data = (rd_wren_r && (rd_addr_r == i_rs2_addr) && (i_rs2_addr != {ADDR_W{1'b0}}))
                    ? rd_data_r : i_rs2_data;
`else
  assign rs1_haz_s = (i_rs1_addr != {ADDR_W{1'b0}}) && pending_r[i_rs1_addr];
  assign rs2_haz_s = (i_rs2_addr != {ADDR_W{1'b0}}) && pending_r[i_rs2_addr];
`endif

  assign o_hazard  = rs1_haz_s || rs2_haz_s;
  assign o_rd_addr = rd_addr_r;
  assign o_rd_data = rd_data_r;
  assign o_rd_wren = rd_wren_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a queue-based reference model.
// Build with WB_FORWARD_EN defined to also cover the bypass ports.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = 5'd0;
  logic [31:0] lsu_data = 32'd0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic        o_lsu_ready;
  logic        o_hazard;
  logic [31:0] o_pending;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;
`ifdef WB_FORWARD_EN
  logic [31:0] rs1_data = 32'h0000_1234;
  logic [31:0] rs2_data = 32'h0000_5678;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
`endif

  int passed = 0;
  int total  = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .RST          (RST),
    .i_alu_valid  (alu_valid),
    .i_alu_rd     (alu_rd),
    .i_alu_data   (alu_data),
    .i_lsu_valid  (lsu_valid),
    .o_lsu_ready  (o_lsu_ready),
    .i_lsu_rd     (lsu_rd),
    .i_lsu_data   (lsu_data),
    .i_issue_valid(issue_valid),
    .i_issue_rd   (issue_rd),
    .i_rs1_addr   (rs1),
    .i_rs2_addr   (rs2),
    .o_hazard     (o_hazard),
    .o_pending    (o_pending),
    .o_rd_addr    (o_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_rd_wren    (o_rd_wren)
`ifdef WB_FORWARD_EN
    ,
    .i_rs1_data   (rs1_data),
    .i_rs2_data   (rs2_data),
    .o_rs1_data   (o_rs1_data),
    .o_rs2_data   (o_rs2_data)
`endif
  );

  // Reference model: state after each clock edge.
  logic        m_wren = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;
  bit          m_src_lsu = 1'b0;
  logic [31:0] m_pend = 32'd0;
  logic [36:0] m_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit exp_haz(input logic [4:0] rs);
    bit h;
    h = (rs != 5'd0) && m_pend[rs];
`ifdef WB_FORWARD_EN
    if (m_wren && m_src_lsu && (m_addr == rs)) h = 1'b0;
`endif
    return h;
  endfunction

  // Model update on every edge from the inputs held over the preceding cycle.
  initial forever begin
    bit          acc;
    logic [36:0] e;
    @(posedge clk or posedge RST);
    if (RST) begin
      m_wren = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_src_lsu = 1'b0;
      m_pend = 32'd0; m_q.delete();
    end else begin
      acc = lsu_valid && (m_q.size() < DEPTH);
      if (m_wren && m_src_lsu) m_pend[m_addr] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
      if (alu_valid && alu_rd != 5'd0) begin
        m_wren = 1'b1; m_addr = alu_rd; m_data = alu_data; m_src_lsu = 1'b0;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_src_lsu = 1'b1;
        if (e[36:32] != 5'd0) begin
          m_wren = 1'b1; m_addr = e[36:32]; m_data = e[31:0];
        end else begin
          m_wren = 1'b0;
        end
      end else begin
        m_wren = 1'b0;
      end
      if (acc) m_q.push_back({lsu_rd, lsu_data});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("wren", {31'd0, o_rd_wren}, {31'd0, m_wren});
      if (m_wren) begin
        chk("addr", {27'd0, o_rd_addr}, {27'd0, m_addr});
        chk("data", o_rd_data, m_data);
      end
      chk("pending", o_pending, m_pend);
      chk("ready", {31'd0, o_lsu_ready}, {31'd0, (m_q.size() < DEPTH)});
      chk("hazard", {31'd0, o_hazard}, {31'd0, (exp_haz(rs1) | exp_haz(rs2))});
`ifdef WB_FORWARD_EN
      chk("rs1_data", o_rs1_data,
          (m_wren && m_addr == rs1 && rs1 != 5'd0) ? m_data : rs1_data);
      chk("rs2_data", o_rs2_data,
          (m_wren && m_addr == rs2 && rs2 != 5'd0) ? m_data : rs2_data);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = 1'b1; lsu_rd = rd; lsu_data = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_rd = rd;
  endtask

  initial begin
    bit acc;
    int k;
    bit ready_c2;
    bit ready_c5;

    // Power-on reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    check_en = 1'b1;
    #1;
    chk("rst_wren", {31'd0, o_rd_wren}, 32'd0);
    chk("rst_addr", {27'd0, o_rd_addr}, 32'd0);
    chk("rst_pending", o_pending, 32'd0);
    chk("rst_ready", {31'd0, o_lsu_ready}, 32'd1);

    // Reset mid-operation drops a buffered load and the pending bit.
    cyc();
    alu(5'd5, 32'h11); issue(5'd9); lsu(5'd6, 32'h66);
    cyc();
    idle(); rs1 = 5'd9;
    #1;
    chk("alu_lat_wren", {31'd0, o_rd_wren}, 32'd1);
    chk("alu_lat_addr", {27'd0, o_rd_addr}, 32'd5);
    chk("alu_lat_data", o_rd_data, 32'h11);
    chk("pend9_set", o_pending, 32'h0000_0200);
    chk("haz_before_rst", {31'd0, o_hazard}, 32'd1);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_wren", {31'd0, o_rd_wren}, 32'd0);
    chk("arst_addr", {27'd0, o_rd_addr}, 32'd0);
    chk("arst_data", o_rd_data, 32'd0);
    chk("arst_pending", o_pending, 32'd0);
    chk("arst_hazard", {31'd0, o_hazard}, 32'd0);
    #1;
    RST = 1'b0;
    rs1 = 5'd0;
    repeat (3) cyc();

    // ALU/LSU collision: ALU holds the port three cycles, load follows.
    alu(5'd3, 32'hA); lsu(5'd7, 32'hB);
    cyc();
    lsu_valid = 1'b0;
    chk("col_n1", {27'd0, o_rd_addr}, 32'd3);
    cyc();
    chk("col_n2", {27'd0, o_rd_addr}, 32'd3);
    cyc();
    alu_valid = 1'b0;
    chk("col_n3", {27'd0, o_rd_addr}, 32'd3);
    cyc();
    chk("col_n4_wren", {31'd0, o_rd_wren}, 32'd1);
    chk("col_n4_addr", {27'd0, o_rd_addr}, 32'd7);
    chk("col_n4_data", o_rd_data, 32'hB);
    repeat (2) cyc();

    // FIFO full: three back-to-back loads while the ALU is busy.
    k = 0; ready_c2 = 1'b1; ready_c5 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) alu(5'd1, 32'(c)); else alu_valid = 1'b0;
      if (k < 3) lsu(5'(10 + k), 32'hC0 + 32'(k)); else lsu_valid = 1'b0;
      #1;
      acc = o_lsu_ready && lsu_valid;
      if (c == 2) ready_c2 = o_lsu_ready;
      if (c == 5) ready_c5 = o_lsu_ready;
      cyc();
      if (acc) k++;
      if (c == 4) chk("drain0", {27'd0, o_rd_addr}, 32'd10);
      if (c == 5) chk("drain1", {27'd0, o_rd_addr}, 32'd11);
      if (c == 6) begin
        chk("drain2_addr", {27'd0, o_rd_addr}, 32'd12);
        chk("drain2_data", o_rd_data, 32'hC2);
      end
    end
    idle();
    chk("full_ready_c2", {31'd0, ready_c2}, 32'd0);
    chk("full_ready_c5", {31'd0, ready_c5}, 32'd1);
    chk("full_accepts", 32'(k), 32'd3);
    repeat (2) cyc();

    // Scoreboard: stall until the edge after the load write; same-cycle set wins.
    issue(5'd9); rs1 = 5'd9;
    cyc();
    issue_valid = 1'b0;
    lsu(5'd9, 32'h99);
    #1;
    chk("sb_haz_set", {31'd0, o_hazard}, 32'd1);
    cyc();
    lsu_valid = 1'b0;
    cyc();
    chk("sb_wr9", {27'd0, o_rd_addr}, 32'd9);
    issue(5'd9);
    #1;
`ifdef WB_FORWARD_EN
    chk("sb_haz_onport_fwd", {31'd0, o_hazard}, 32'd0);
`else
    chk("sb_haz_onport", {31'd0, o_hazard}, 32'd1);
`endif
    cyc();
    issue_valid = 1'b0;
    chk("sb_set_wins", {31'd0, o_pending[9]}, 32'd1);
    lsu(5'd9, 32'h98);
    cyc();
    lsu_valid = 1'b0;
    repeat (2) cyc();
    chk("sb_cleared", o_pending, 32'd0);
    chk("sb_haz_clr", {31'd0, o_hazard}, 32'd0);
    rs1 = 5'd0;
    cyc();

    // x0 results and issue.
    alu(5'd0, 32'h55); lsu(5'd0, 32'h77); issue(5'd0);
    #1;
    chk("x0_haz", {31'd0, o_hazard}, 32'd0);
    cyc();
    idle(); lsu(5'd8, 32'h88);
    chk("x0_alu_wren", {31'd0, o_rd_wren}, 32'd0);
    cyc();
    lsu_valid = 1'b0;
    chk("x0_lsu_wren", {31'd0, o_rd_wren}, 32'd0);
    chk("x0_pending", o_pending, 32'd0);
    cyc();
    chk("x0_popped_addr", {27'd0, o_rd_addr}, 32'd8);
    chk("x0_popped_data", o_rd_data, 32'h88);
    cyc();

    // Load of x4 on the port while decode reads rs2=4.
    issue(5'd4);
    cyc();
    issue_valid = 1'b0; lsu(5'd4, 32'hDEAD);
    cyc();
    lsu_valid = 1'b0;
    cyc();
    rs2 = 5'd4;
`ifdef WB_FORWARD_EN
    rs2_data = 32'd0;
`endif
    #1;
    chk("fw_addr", {27'd0, o_rd_addr}, 32'd4);
`ifdef WB_FORWARD_EN
    chk("fw_rs2_data", o_rs2_data, 32'hDEAD);
    chk("fw_hazard", {31'd0, o_hazard}, 32'd0);
`else
    chk("nofw_hazard", {31'd0, o_hazard}, 32'd1);
`endif
    cyc();
    #1;
    chk("fw_after_pending", o_pending, 32'd0);
    rs2 = 5'd0;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
